game_tick_gen: RTL

- Parametrised, single-clock tick generator for the game cores (GameStacker and successors).
- Replaces the ripple-clocked chain of fixed timers with a clk-domain prescaler plus NUM_STAGES cascaded, runtime-reprogrammable dividers.
- Each stage emits a one-clk-wide enable pulse. Game logic runs on clk and qualifies its updates with those pulses.
- Adds pause, phase restart, shadowed divisor reload and a difficulty speed-up on the last stage.

---
 rtl/game_tick_gen_pkg.sv | 17 +
 rtl/game_tick_gen_if.sv | 25 ++
 rtl/game_tick_gen_stage.sv | 76 +++++++
 rtl/game_tick_gen.sv | 105 ++++++++++
 4 files changed

// File: rtl/game_tick_gen_pkg.sv
// Shared constants and helpers for the game tick generator.
package game_tick_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int DIVS_MAX_W = 8 * 32;

    typedef logic [CNT_W_DEF-1:0] div_t;

    // Pull the default divisor of stage k out of a packed, LSB-first divisor list.
    function automatic logic [31:0] div_slice(input logic [DIVS_MAX_W-1:0] divs,
                                              input int k, input int w);
        logic [DIVS_MAX_W-1:0] sh;
        sh = divs >> (k * w);
        return sh[31:0] & ((32'h1 << w) - 32'h1);
    endfunction

endpackage

// File: rtl/game_tick_gen_if.sv
// Control/status bundle between game logic and the tick generator.
interface game_tick_gen_if #(
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 8
);
    logic                  enable;
    logic                  restart;
    logic                  cfg_we;
    logic [2:0]            cfg_sel;
    logic [CNT_W-1:0]      cfg_div;
    logic                  speed_up;
    logic [NUM_STAGES-1:0] tick_out;
    logic [CNT_W-1:0]      cur_div;
    logic                  led;

    modport master (
        output enable, restart, cfg_we, cfg_sel, cfg_div, speed_up,
        input  tick_out, cur_div, led
    );

    modport slave (
        input  enable, restart, cfg_we, cfg_sel, cfg_div, speed_up,
        output tick_out, cur_div, led
    );
endinterface

// File: rtl/game_tick_gen_stage.sv
// One divider stage: counter plus active/shadow divisor pair with wrap-aligned reload.
module tick_div_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             enable,
    input  logic             in_pulse,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             dec,
    input  logic [CNT_W-1:0] min_div,
    input  logic [CNT_W-1:0] def_div,
    output logic             out_pulse,
    output logic [CNT_W-1:0] act_div
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shad_q, shad_d;
    logic             out_q, out_d;
    logic             wrap;

    always_comb begin
        shad_d = shad_q;
        act_d  = act_q;
        cnt_d  = cnt_q;
        out_d  = 1'b0;
        wrap   = 1'b0;

        if (wr) begin
            shad_d = wr_div;
        end else if (dec && (shad_q > min_div)) begin
            shad_d = shad_q - CNT_W'(1);
            if (act_q > min_div) begin
                act_d = act_q - CNT_W'(1);
            end
        end

        // ">=" lets a speed-up that lands below the current count wrap on the next pulse.
        if (restart) begin
            cnt_d = '0;
        end else if (enable && in_pulse && (act_q != '0)) begin
            if (cnt_q >= act_q - CNT_W'(1)) begin
                cnt_d = '0;
                out_d = 1'b1;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (wrap || (act_q == '0)) begin
            act_d = shad_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            act_q  <= def_div;
            shad_q <= def_div;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            act_q  <= act_d;
            shad_q <= shad_d;
        end
    end

    assign out_pulse = out_q;
    assign act_div   = act_q;

endmodule

// File: rtl/game_tick_gen.sv
// Prescaler plus NUM_STAGES cascaded dividers producing one-clk enable pulses.
// Optional heartbeat LED on the last stage is built when TICK_LED_EN is defined.
module game_tick_gen
    import game_tick_pkg::*;
#(
    parameter int                          PRESCALE   = 50000,
    parameter int                          NUM_STAGES = 2,
    parameter int                          CNT_W      = 8,
    parameter logic [NUM_STAGES*CNT_W-1:0] DEF_DIVS   = {8'd5, 8'd200},
    parameter int                          MIN_DIV    = 1
) (
    input logic            clk,
    input logic            rst,
    game_tick_gen_if.slave bus
);

    localparam int PW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int LAST = NUM_STAGES - 1;
    localparam logic [CNT_W-1:0] DEF_LAST =
        CNT_W'(div_slice(DIVS_MAX_W'(DEF_DIVS), LAST, CNT_W));

    logic [PW-1:0]               presc_q, presc_d;
    logic                        base_tick;
    logic [NUM_STAGES-1:0]       tick;
    logic [NUM_STAGES-1:0]       pulse_in;
    logic [NUM_STAGES*CNT_W-1:0] act_all;
    logic [CNT_W-1:0]            cur_div_q;
    logic                        last_wr;

    // base_tick is combinational so a pause never swallows a pending base tick.
    assign base_tick = bus.enable && !bus.restart && (presc_q == PW'(PRESCALE - 1));

    always_comb begin
        presc_d = presc_q;
        if (bus.restart) begin
            presc_d = '0;
        end else if (bus.enable) begin
            presc_d = base_tick ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign last_wr = bus.cfg_we && (bus.cfg_sel == 3'(LAST));

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam logic [CNT_W-1:0] DEF_K =
            CNT_W'(div_slice(DIVS_MAX_W'(DEF_DIVS), k, CNT_W));

        if (k == 0) begin : g_first
            assign pulse_in[k] = base_tick;
        end else begin : g_chain
            assign pulse_in[k] = tick[k-1];
        end

        tick_div_stage #(.CNT_W(CNT_W)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .restart  (bus.restart),
            .enable   (bus.enable),
            .in_pulse (pulse_in[k]),
            .wr       (bus.cfg_we && (bus.cfg_sel == 3'(k))),
            .wr_div   (bus.cfg_div),
            .dec      ((k == LAST) && bus.speed_up && !last_wr),
            .min_div  (CNT_W'(MIN_DIV)),
            .def_div  (DEF_K),
            .out_pulse(tick[k]),
            .act_div  (act_all[k*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_div_q <= DEF_LAST;
        end else begin
            cur_div_q <= act_all[LAST*CNT_W +: CNT_W];
        end
    end

    assign bus.tick_out = tick;
    assign bus.cur_div  = cur_div_q;

`ifdef TICK_LED_EN
    logic led_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 1'b0;
        end else if (tick[LAST]) begin
            led_q <= ~led_q;
        end
    end

    assign bus.led = led_q;
`else
    assign bus.led = 1'b0;
`endif

endmodule
